// File: rtl/pgr_apb_cmd_arb_pkg.sv
// Shared types and widths for the APB command arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pgr_apb_arb_pkg;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 32;
  localparam int STRB_W       = 4;
  localparam int WDOG_CYC_DEF = 1023;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/pgr_apb_cmd_arb_if.sv
// Bundle of requester-side and APB-command-side signals around the arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req_vld until req_ack; the APB side finishes with cmd_done.
interface pgr_apb_cmd_arb_if
  import pgr_apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  // Requester side: slice i of every vector belongs to requester i.
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*STRB_W-1:0] req_strb;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        rsp_vld;
  logic                      rsp_err;
  logic [DATA_W-1:0]         rsp_rdata;

  // Command port towards the APB master interface.
  logic                      cmd_en;
  logic                      cmd_we;
  logic [STRB_W-1:0]         cmd_strb;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [DATA_W-1:0]         cmd_data;
  logic                      cmd_done;
  logic [DATA_W-1:0]         p_rdata;

  logic                      busy;

  // The arbiter itself.
  modport slave (
    input  req_vld, req_we, req_strb, req_addr, req_data, cmd_done, p_rdata,
    output req_ack, rsp_vld, rsp_err, rsp_rdata,
    output cmd_en, cmd_we, cmd_strb, cmd_addr, cmd_data, busy
  );

  // Whatever surrounds the arbiter: requesters plus the APB master interface.
  modport master (
    output req_vld, req_we, req_strb, req_addr, req_data, cmd_done, p_rdata,
    input  req_ack, rsp_vld, rsp_err, rsp_rdata,
    input  cmd_en, cmd_we, cmd_strb, cmd_addr, cmd_data, busy
  );

endinterface

// File: rtl/pgr_apb_cmd_arb_rr_sel.sv
// Round-robin pick: first valid requester after last_gnt, wrapping at NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module pgr_rr_sel #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [$clog2(NUM_REQ)-1:0] last_gnt,
  output logic [$clog2(NUM_REQ)-1:0] sel,
  output logic                       any_vld
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] sel_hi;
  logic [IDX_W-1:0] sel_lo;
  logic             found_hi;
  logic             found_lo;

  // Lowest valid index above last_gnt wins; otherwise wrap to the lowest valid
  // index at or below it. Scanning downwards leaves the lowest match in place.
  always_comb begin
    sel_hi   = '0;
    sel_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_vld[i]) begin
        if (IDX_W'(i) > last_gnt) begin
          found_hi = 1'b1;
          sel_hi   = IDX_W'(i);
        end else begin
          found_lo = 1'b1;
          sel_lo   = IDX_W'(i);
        end
      end
    end
  end

  assign any_vld = found_hi | found_lo;
  assign sel     = found_hi ? sel_hi : sel_lo;

endmodule

// File: rtl/pgr_apb_cmd_arb.sv
// Arbitrates NUM_REQ command requesters onto one APB command port, one command in flight.
// Latency: req_ack 1 cycle after req_vld is seen in IDLE, cmd_en 1 cycle later, rsp_vld 1 cycle after cmd_done.
// Backpressure: requests wait while busy; WAIT holds until cmd_done (or the watchdog when APB_ARB_WDOG_EN is defined).
module pgr_apb_cmd_arb
  import pgr_apb_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WDOG_CYC = WDOG_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  pgr_apb_cmd_arb_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Catch bad parameterisation at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("pgr_apb_cmd_arb: NUM_REQ must be within 2..8");
  end
  if (WDOG_CYC < 1) begin : g_bad_wdog
    $error("pgr_apb_cmd_arb: WDOG_CYC must be at least 1");
  end

  arb_state_e         state_q;
  arb_state_e         state_d;

  logic [IDX_W-1:0]   sel;
  logic               any_vld;
  logic [IDX_W-1:0]   gnt_q;
  logic [IDX_W-1:0]   last_gnt_q;

  logic               load_cmd;
  logic               issue;
  logic               done_ok;
  logic               tmo;
  logic               wdog_hit;
  logic               rsp_fire;

  logic [NUM_REQ-1:0] req_ack_q;
  logic [NUM_REQ-1:0] rsp_vld_q;
  logic               cmd_en_q;
  logic               cmd_we_q;
  logic [STRB_W-1:0]  cmd_strb_q;
  logic [ADDR_W-1:0]  cmd_addr_q;
  logic [DATA_W-1:0]  cmd_data_q;
  logic [DATA_W-1:0]  rsp_rdata_q;

  // Per-requester views of the packed request fields, indexed by the pick.
  logic               we_arr   [NUM_REQ];
  logic [STRB_W-1:0]  strb_arr [NUM_REQ];
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_view
    assign we_arr[g]   = bus.req_we[g];
    assign strb_arr[g] = bus.req_strb[g*STRB_W +: STRB_W];
    assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  pgr_rr_sel #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_sel (
    .req_vld  (bus.req_vld),
    .last_gnt (last_gnt_q),
    .sel      (sel),
    .any_vld  (any_vld)
  );

  // State register; reset drops any command in flight straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the one-cycle strobes that steer the datapath.
  // cmd_done only counts in WAIT; in every other state it is ignored.
  always_comb begin
    state_d  = state_q;
    load_cmd = 1'b0;
    issue    = 1'b0;
    done_ok  = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_vld) begin
          load_cmd = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion in the same cycle as the timeout takes precedence.
        if (bus.cmd_done) begin
          done_ok = 1'b1;
          state_d = ST_RESP;
        end else if (wdog_hit) begin
          tmo     = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rsp_fire = done_ok | tmo;

  // Command latch, handshake pulses and response data.
  // cmd_* fields load only when leaving IDLE, so they are stable through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      last_gnt_q  <= IDX_W'(NUM_REQ - 1);
      req_ack_q   <= '0;
      rsp_vld_q   <= '0;
      cmd_en_q    <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_strb_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      req_ack_q <= load_cmd ? (NUM_REQ'(1) << sel) : '0;
      rsp_vld_q <= rsp_fire ? (NUM_REQ'(1) << gnt_q) : '0;
      cmd_en_q  <= issue;
      if (load_cmd) begin
        gnt_q      <= sel;
        cmd_we_q   <= we_arr[sel];
        cmd_strb_q <= strb_arr[sel];
        cmd_addr_q <= addr_arr[sel];
        cmd_data_q <= data_arr[sel];
      end
      if (state_q == ST_RESP) begin
        last_gnt_q <= gnt_q;
      end
      // Writes and timeouts return zero; the value holds until the next response.
      if (rsp_fire) begin
        rsp_rdata_q <= (cmd_we_q || tmo) ? '0 : bus.p_rdata;
      end
    end
  end

`ifdef APB_ARB_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);

  logic [WD_W-1:0] wdog_cnt_q;
  logic            rsp_err_q;

  // Counts cycles spent in WAIT; cleared on the way in from ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
    end else if (issue) begin
      wdog_cnt_q <= '0;
    end else if (state_q == ST_WAIT && !wdog_hit) begin
      wdog_cnt_q <= wdog_cnt_q + 1'b1;
    end
  end

  // Fires in the WDOG_CYC-th cycle of WAIT.
  assign wdog_hit = (state_q == ST_WAIT) && (wdog_cnt_q == WD_W'(WDOG_CYC - 1));

  // Error flag rides alongside the rsp_vld pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= tmo;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign wdog_hit    = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ack   = req_ack_q;
  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.cmd_en    = cmd_en_q;
  assign bus.cmd_we    = cmd_we_q;
  assign bus.cmd_strb  = cmd_strb_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.cmd_data  = cmd_data_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pgr_apb_cmd_arb.sv
// Scoreboard bench for pgr_apb_cmd_arb: expectations are queued with the stimulus,
// a monitor pops them on every req_ack, cmd_en and rsp_vld pulse.
// Watchdog cases are included when APB_ARB_WDOG_EN is defined.
module tb_pgr_apb_cmd_arb;
  import pgr_apb_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int WDOG = 16;

  typedef struct {
    logic        we;
    logic [3:0]  strb;
    logic [15:0] addr;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pgr_apb_cmd_arb_if #(.NUM_REQ(NREQ)) bus ();

  pgr_apb_cmd_arb #(
    .NUM_REQ  (NREQ),
    .WDOG_CYC (WDOG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   exp_gnt_q[$];
  cmd_t exp_cmd_q[$];
  rsp_t exp_rsp_q[$];

  int n_cmp    = 0;
  int n_err    = 0;
  int ack_seen = 0;
  bit rsp_auto = 1'b0;
  int rsp_delay = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected pulse, got %h, expected none", name, act);
  endtask

  function automatic logic [NREQ-1:0] onehot(input int idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // APB side model: read data as a function of the address.
  function automatic logic [31:0] rdata_for(input logic [15:0] addr);
    return (addr == 16'h0010) ? 32'hDEADBEEF : {16'hD0D0, addr};
  endfunction

  task automatic push_cmd(input int idx, input logic we, input logic [3:0] strb,
                          input logic [15:0] addr, input logic [31:0] data);
    cmd_t c;
    c.we = we; c.strb = strb; c.addr = addr; c.data = data;
    exp_gnt_q.push_back(idx);
    exp_cmd_q.push_back(c);
  endtask

  task automatic push_rsp(input int idx, input logic err, input logic [31:0] rdata);
    rsp_t r;
    r.idx = idx; r.err = err; r.rdata = rdata;
    exp_rsp_q.push_back(r);
  endtask

  task automatic set_req(input int i, input logic we, input logic [3:0] strb,
                         input logic [15:0] addr, input logic [31:0] data);
    bus.req_we[i]            = we;
    bus.req_strb[i*4 +: 4]   = strb;
    bus.req_addr[i*16 +: 16] = addr;
    bus.req_data[i*32 +: 32] = data;
    bus.req_vld[i]           = 1'b1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Hold request i until its ack, then drop it after the next edge.
  task automatic req_until_ack(input int i, input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ack[i]) got = 1'b1;
    end
    if (!got) unexpected({name, "_ack_timeout"}, 64'(bus.req_ack));
    next_cyc();
    bus.req_vld[i] = 1'b0;
  endtask

  // Wait until the DUT is idle and every expectation was consumed.
  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (!bus.busy && exp_gnt_q.size() == 0 && exp_cmd_q.size() == 0 && exp_rsp_q.size() == 0)
        done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_drain: busy=%0b, pending gnt/cmd/rsp=%0d/%0d/%0d, expected idle and empty",
               name, bus.busy, exp_gnt_q.size(), exp_cmd_q.size(), exp_rsp_q.size());
    end
    next_cyc();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ack"},   64'(bus.req_ack),   64'(0));
    chk({tag, "_rsp_vld"},   64'(bus.rsp_vld),   64'(0));
    chk({tag, "_rsp_err"},   64'(bus.rsp_err),   64'(0));
    chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(0));
    chk({tag, "_cmd_en"},    64'(bus.cmd_en),    64'(0));
    chk({tag, "_cmd_we"},    64'(bus.cmd_we),    64'(0));
    chk({tag, "_cmd_strb"},  64'(bus.cmd_strb),  64'(0));
    chk({tag, "_cmd_addr"},  64'(bus.cmd_addr),  64'(0));
    chk({tag, "_cmd_data"},  64'(bus.cmd_data),  64'(0));
    chk({tag, "_busy"},      64'(bus.busy),      64'(0));
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses an output.
  initial begin
    int   g;
    cmd_t c;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.req_ack != '0) begin
          ack_seen++;
          if (exp_gnt_q.size() == 0) unexpected("req_ack", 64'(bus.req_ack));
          else begin
            g = exp_gnt_q.pop_front();
            chk("req_ack", 64'(bus.req_ack), 64'(onehot(g)));
          end
        end
        if (bus.cmd_en) begin
          if (exp_cmd_q.size() == 0) unexpected("cmd_en", 64'(bus.cmd_addr));
          else begin
            c = exp_cmd_q.pop_front();
            chk("cmd_fields", {11'd0, bus.cmd_we, bus.cmd_strb, bus.cmd_addr, bus.cmd_data},
                {11'd0, c.we, c.strb, c.addr, c.data});
          end
        end
        if (bus.rsp_vld != '0) begin
          if (exp_rsp_q.size() == 0) unexpected("rsp_vld", 64'(bus.rsp_vld));
          else begin
            r = exp_rsp_q.pop_front();
            chk("rsp", {27'd0, bus.rsp_vld, bus.rsp_err, bus.rsp_rdata},
                {27'd0, onehot(r.idx), r.err, r.rdata});
          end
        end
      end
    end
  end

  // APB responder: rsp_delay edges after cmd_en, pulse cmd_done for one cycle.
  initial begin
    logic [15:0] a;
    forever begin
      @(negedge clk);
      if (rst_n && bus.cmd_en && rsp_auto) begin
        a = bus.cmd_addr;
        repeat (rsp_delay) @(posedge clk);
        #1;
        bus.cmd_done = 1'b1;
        bus.p_rdata  = rdata_for(a);
        @(posedge clk);
        #1;
        bus.cmd_done = 1'b0;
        bus.p_rdata  = '0;
      end
    end
  end

  // Overall time limit.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d failures before timeout", n_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "global timeout");
  end

  // Directed stimulus.
  initial begin
    bus.req_vld  = '0;
    bus.req_we   = '0;
    bus.req_strb = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.cmd_done = 1'b0;
    bus.p_rdata  = '0;

    // Reset state: every output low.
    @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();
    next_cyc();

    // Single read from requester 0; APB completes in cycle 5.
    rsp_auto  = 1'b1;
    rsp_delay = 3;
    push_cmd(0, 1'b0, 4'hF, 16'h0010, 32'h0);
    push_rsp(0, 1'b0, 32'hDEADBEEF);
    set_req(0, 1'b0, 4'hF, 16'h0010, 32'h0);
    @(negedge clk);
    chk("rd_ack_c0", 64'(bus.req_ack), 64'(0));
    @(negedge clk);
    chk("rd_ack_c1", 64'(bus.req_ack), 64'(4'b0001));
    next_cyc();
    bus.req_vld[0] = 1'b0;
    @(negedge clk);
    chk("rd_cmd_en_c2", 64'(bus.cmd_en), 64'(1));
    repeat (4) @(negedge clk);
    chk("rd_rsp_vld_c6", 64'(bus.rsp_vld), 64'(4'b0001));
    repeat (2) @(negedge clk);
    chk("rd_rdata_hold", 64'(bus.rsp_rdata), 64'(32'hDEADBEEF));
    wait_idle("rd");

    // Write from requester 2: read data from the APB side must not leak through.
    rsp_delay = 2;
    push_cmd(2, 1'b1, 4'hF, 16'h0200, 32'h12345678);
    push_rsp(2, 1'b0, 32'h0);
    set_req(2, 1'b1, 4'hF, 16'h0200, 32'h12345678);
    req_until_ack(2, "wr");
    wait_idle("wr");
    chk("wr_rdata_zero", 64'(bus.rsp_rdata), 64'(0));

    // Stray cmd_done in IDLE.
    rsp_auto     = 1'b0;
    bus.cmd_done = 1'b1;
    bus.p_rdata  = 32'hBAD0BAD0;
    @(negedge clk);
    chk("stray_idle_busy", 64'(bus.busy), 64'(0));
    next_cyc();
    bus.cmd_done = 1'b0;
    bus.p_rdata  = '0;
    @(negedge clk);
    chk("stray_idle_busy2", 64'(bus.busy), 64'(0));
    chk("stray_idle_rdata", 64'(bus.rsp_rdata), 64'(0));
    next_cyc();

    // Stray cmd_done in ISSUE, then the real completion in cycle 4.
    push_cmd(1, 1'b0, 4'h3, 16'h0300, 32'h0);
    push_rsp(1, 1'b0, 32'h11112222);
    set_req(1, 1'b0, 4'h3, 16'h0300, 32'h0);
    next_cyc();
    bus.cmd_done = 1'b1;
    bus.p_rdata  = 32'hBAD0BAD0;
    @(negedge clk);
    chk("stray_issue_ack", 64'(bus.req_ack), 64'(4'b0010));
    next_cyc();
    bus.cmd_done   = 1'b0;
    bus.p_rdata    = '0;
    bus.req_vld[1] = 1'b0;
    @(negedge clk);
    chk("stray_issue_cmd_en", 64'(bus.cmd_en), 64'(1));
    next_cyc();
    @(negedge clk);
    chk("stray_issue_no_rsp", 64'(bus.rsp_vld), 64'(0));
    chk("stray_issue_busy", 64'(bus.busy), 64'(1));
    next_cyc();
    bus.cmd_done = 1'b1;
    bus.p_rdata  = 32'h11112222;
    next_cyc();
    bus.cmd_done = 1'b0;
    bus.p_rdata  = '0;
    wait_idle("stray_issue");

    // Reset in WAIT: outputs clear at once, the command gets no response.
    push_cmd(3, 1'b0, 4'h1, 16'h0400, 32'h0);
    set_req(3, 1'b0, 4'h1, 16'h0400, 32'h0);
    next_cyc();
    next_cyc();
    bus.req_vld[3] = 1'b0;
    next_cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_wait");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_wait_gnt_q", 64'(exp_gnt_q.size()), 64'(0));
    chk("rst_wait_cmd_q", 64'(exp_cmd_q.size()), 64'(0));
    next_cyc();

    // Round robin after reset: all four held high, grants 0,1,2,3,0.
    rsp_auto  = 1'b1;
    rsp_delay = 1;
    push_cmd(0, 1'b0, 4'h1, 16'h1000, 32'h0); push_rsp(0, 1'b0, 32'hD0D01000);
    push_cmd(1, 1'b0, 4'h2, 16'h1100, 32'h0); push_rsp(1, 1'b0, 32'hD0D01100);
    push_cmd(2, 1'b0, 4'h4, 16'h1200, 32'h0); push_rsp(2, 1'b0, 32'hD0D01200);
    push_cmd(3, 1'b0, 4'h8, 16'h1300, 32'h0); push_rsp(3, 1'b0, 32'hD0D01300);
    push_cmd(0, 1'b0, 4'h1, 16'h1000, 32'h0); push_rsp(0, 1'b0, 32'hD0D01000);
    begin
      int base;
      bit got5;
      base = ack_seen;
      got5 = 1'b0;
      set_req(0, 1'b0, 4'h1, 16'h1000, 32'h0);
      set_req(1, 1'b0, 4'h2, 16'h1100, 32'h0);
      set_req(2, 1'b0, 4'h4, 16'h1200, 32'h0);
      set_req(3, 1'b0, 4'h8, 16'h1300, 32'h0);
      for (int k = 0; k < 200 && !got5; k++) begin
        @(negedge clk);
        if (ack_seen - base >= 5) got5 = 1'b1;
      end
      if (!got5) unexpected("rr_ack_count_timeout", 64'(ack_seen - base));
      next_cyc();
      bus.req_vld = '0;
    end
    wait_idle("rr");

`ifdef APB_ARB_WDOG_EN
    // No completion: timeout response with error and zero data.
    rsp_auto = 1'b0;
    push_cmd(0, 1'b0, 4'hF, 16'h0500, 32'h0);
    push_rsp(0, 1'b1, 32'h0);
    set_req(0, 1'b0, 4'hF, 16'h0500, 32'h0);
    req_until_ack(0, "wdog");
    wait_idle("wdog");

    // Completion lands in the timeout cycle (16th cycle of WAIT): completion wins.
    rsp_auto  = 1'b1;
    rsp_delay = WDOG - 1;
    push_cmd(0, 1'b0, 4'hF, 16'h0500, 32'h0);
    push_rsp(0, 1'b0, 32'hD0D00500);
    set_req(0, 1'b0, 4'hF, 16'h0500, 32'h0);
    req_until_ack(0, "wdog_race");
    wait_idle("wdog_race");
`else
    // Without the watchdog a slow completion is still a clean response.
    rsp_auto  = 1'b1;
    rsp_delay = 30;
    push_cmd(1, 1'b0, 4'hF, 16'h0600, 32'h0);
    push_rsp(1, 1'b0, 32'hD0D00600);
    set_req(1, 1'b0, 4'hF, 16'h0600, 32'h0);
    req_until_ack(1, "slow");
    wait_idle("slow");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
